// File: rtl/interface_hcsr04_medida.sv
// -----------------------------------------------------------------------------
// interface_hcsr04_medida
//
// HC-SR04 ultrasonic ranging front end. A measure request fires a trigger
// pulse. The block then times the echo pulse and converts its width to
// centimetres as three BCD digits. A one-cycle pronto strobe tells the
// downstream serial stage that medida is ready.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   medir     in   measure request (sampled only in the idle state)
//   echo      in   sensor echo, asynchronous; double-flop synchronized here
//   trigger   out  registered sensor trigger pulse (TRIGGER_CICLOS wide)
//   medida    out  distance {hundreds, tens, units} BCD, cm, saturates at 999
//   pronto    out  registered one-cycle strobe at the end of a measurement
//   timeout   out  one-cycle strobe alongside pronto when the watchdog fired
//   db_estado out  current FSM state code
//
// Optional feature: define HCSR04_TIMEOUT_EN to build the echo watchdog
// (TIMEOUT_CICLOS). Without it the FSM waits for echo indefinitely and
// timeout is held at 0.
// -----------------------------------------------------------------------------
module interface_hcsr04_medida #(
  parameter int TRIGGER_CICLOS = 500,
  parameter int CICLOS_POR_CM  = 2941,
  parameter int TIMEOUT_CICLOS = 1500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        timeout,
  output logic [3:0]  db_estado
);

  typedef enum logic [3:0] {
    ST_INICIAL       = 4'd0,
    ST_PREPARACAO    = 4'd1,
    ST_ENVIA_TRIGGER = 4'd2,
    ST_ESPERA_ECHO   = 4'd3,
    ST_MEDIDA_ECHO   = 4'd4,
    ST_ARMAZENA      = 4'd5,
    ST_FINAL         = 4'd6,
    ST_TIMEOUT       = 4'd7
  } estado_t;

  // One shared counter times both the trigger pulse and each centimetre.
  localparam int CNT_MAX = (TRIGGER_CICLOS > CICLOS_POR_CM) ? TRIGGER_CICLOS : CICLOS_POR_CM;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] TRIG_ULT = CNT_W'(TRIGGER_CICLOS - 1);
  localparam logic [CNT_W-1:0] CM_ULT   = CNT_W'(CICLOS_POR_CM - 1);

  // Saturating three-digit BCD increment: 999 holds instead of wrapping.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] c, d, u;
    {c, d, u} = v;
    if (v == 12'h999) return v;
    if (u == 4'd9) begin
      u = 4'd0;
      if (d == 4'd9) begin
        d = 4'd0;
        c = c + 4'd1;
      end else begin
        d = d + 4'd1;
      end
    end else begin
      u = u + 4'd1;
    end
    return {c, d, u};
  endfunction

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [11:0]      medida_q, medida_d;
  logic             trigger_q, trigger_d;
  logic             pronto_q, pronto_d;
  logic             echo_meta_q, echo_s_q, echo_prev_q;
  logic             echo_sobe, echo_desce;

  // Edges are taken on the synchronized echo, so a level already high when
  // espera_echo is entered does not count as a rising edge.
  assign echo_sobe  = echo_s_q & ~echo_prev_q;
  assign echo_desce = ~echo_s_q & echo_prev_q;

`ifdef HCSR04_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [WD_W-1:0] WD_ULT = WD_W'(TIMEOUT_CICLOS - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    medida_d = medida_q;
    case (estado_q)
      ST_INICIAL:       if (medir) estado_d = ST_PREPARACAO;
      ST_PREPARACAO: begin
        cnt_d    = '0;
        bcd_d    = 12'h000;
        estado_d = ST_ENVIA_TRIGGER;
      end
      ST_ENVIA_TRIGGER: begin
        if (cnt_q == TRIG_ULT) begin
          cnt_d    = '0;
          estado_d = ST_ESPERA_ECHO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ESPERA_ECHO:   if (echo_sobe) estado_d = ST_MEDIDA_ECHO;
      ST_MEDIDA_ECHO: begin
        // The falling-edge cycle still counts, so an N-cycle echo yields
        // exactly N counts; the leftover partial centimetre is dropped.
        if (cnt_q == CM_ULT) begin
          cnt_d = '0;
          bcd_d = bcd_inc(bcd_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (echo_desce) estado_d = ST_ARMAZENA;
      end
      ST_ARMAZENA: begin
        medida_d = bcd_q;
        estado_d = ST_FINAL;
      end
      ST_FINAL:         estado_d = ST_INICIAL;
      ST_TIMEOUT:       estado_d = ST_INICIAL;
      default:          estado_d = ST_INICIAL;
    endcase

`ifdef HCSR04_TIMEOUT_EN
    // Watchdog runs only while waiting for or timing the echo; it sits at
    // zero elsewhere, which clears it on entry to espera_echo.
    wd_d = '0;
    if (estado_q == ST_ESPERA_ECHO || estado_q == ST_MEDIDA_ECHO) begin
      if (wd_q == WD_ULT) begin
        estado_d = ST_TIMEOUT;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
    timeout_d = (estado_d == ST_TIMEOUT);
`endif

    // Outputs decoded from the next state and registered, so they are glitch free.
    trigger_d = (estado_d == ST_ENVIA_TRIGGER);
    pronto_d  = (estado_d == ST_FINAL) || (estado_d == ST_TIMEOUT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= ST_INICIAL;
      cnt_q       <= '0;
      bcd_q       <= 12'h000;
      medida_q    <= 12'h000;
      trigger_q   <= 1'b0;
      pronto_q    <= 1'b0;
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      medida_q    <= medida_d;
      trigger_q   <= trigger_d;
      pronto_q    <= pronto_d;
      echo_meta_q <= echo;
      echo_s_q    <= echo_meta_q;
      echo_prev_q <= echo_s_q;
    end
  end

`ifdef HCSR04_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  // No watchdog in this build; the parameter is kept so both builds share
  // one interface.
  assign timeout = 1'b0 & (TIMEOUT_CICLOS != 0);
`endif

  assign trigger   = trigger_q;
  assign pronto    = pronto_q;
  assign medida    = medida_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_interface_hcsr04_medida.sv
// -----------------------------------------------------------------------------
// tb_interface_hcsr04_medida
//
// Scoreboard bench for interface_hcsr04_medida with small timing parameters
// (trigger 5 cycles, 10 cycles per cm). Each echo pulse pushes the expected
// distance and the cycle at which pronto must appear; a monitor on the
// falling clock edge pops and compares whenever pronto is high, and also
// checks the trigger pulse width.
// -----------------------------------------------------------------------------
module tb_interface_hcsr04_medida;

  localparam int T   = 5;
  localparam int CPC = 10;
  localparam int TO  = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        medir = 1'b0;
  logic        echo  = 1'b0;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        timeout;
  logic [3:0]  db_estado;

  interface_hcsr04_medida #(
    .TRIGGER_CICLOS(T),
    .CICLOS_POR_CM (CPC),
    .TIMEOUT_CICLOS(TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .medir    (medir),
    .echo     (echo),
    .trigger  (trigger),
    .medida   (medida),
    .pronto   (pronto),
    .timeout  (timeout),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] q_med[$];
  int          q_cyc[$];
  logic        q_to[$];
  logic [11:0] last_med = 12'h000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: trigger width and scoreboard pop on pronto.
  initial begin : monitor
    int   trig_run;
    logic pronto_prev;
    trig_run    = 0;
    pronto_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        trig_run    = 0;
        pronto_prev = 1'b0;
      end else begin
        if (trigger) begin
          trig_run++;
        end else if (trig_run > 0) begin
          check("trigger_width", trig_run, T);
          trig_run = 0;
        end
        if (pronto) begin
          if (pronto_prev) begin
            check("pronto_one_cycle", {31'd0, pronto_prev}, 32'd0);
          end else if (q_med.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pronto: pronto high with nothing expected, medida=%0h (cycle %0d)", medida, cyc);
          end else begin
            check("medida", {20'd0, medida}, {20'd0, q_med.pop_front()});
            check("pronto_cycle", cyc, q_cyc.pop_front());
            check("timeout_flag", {31'd0, timeout}, {31'd0, q_to.pop_front()});
          end
        end
        pronto_prev = pronto;
      end
    end
  end

  initial begin : guard
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d, required below 200000", cyc);
    $fatal(1, "time limit");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic start_medida();
    medir = 1'b1;
    tick(1);
    medir = 1'b0;
  endtask

  task automatic wait_trigger_done();
    int k;
    k = 0;
    while (trigger !== 1'b1 && k < 50) begin
      tick(1);
      k++;
    end
    if (trigger !== 1'b1) check("trigger_start", {31'd0, trigger}, 32'd1);
    k = 0;
    while (trigger !== 1'b0 && k < 50) begin
      tick(1);
      k++;
    end
    check("estado_espera", {28'd0, db_estado}, 32'd3);
  endtask

  // Echo high for n sampling edges; pronto expected 4 cycles after the fall.
  task automatic pulse_echo(input int n, input logic [11:0] exp);
    echo = 1'b1;
    tick(n);
    echo = 1'b0;
    q_med.push_back(exp);
    q_cyc.push_back(cyc + 4);
    q_to.push_back(1'b0);
    last_med = exp;
  endtask

  task automatic measure(input int n, input logic [11:0] exp);
    start_medida();
    wait_trigger_done();
    tick(3);
    pulse_echo(n, exp);
    tick(8);
  endtask

  int          b2b_n[3] = '{25, 43, 9};
  logic [11:0] b2b_e[3] = '{12'h002, 12'h004, 12'h000};

  initial begin : stimulus
    tick(3);
    check("rst_trigger", {31'd0, trigger}, 32'd0);
    check("rst_pronto",  {31'd0, pronto},  32'd0);
    check("rst_medida",  {20'd0, medida},  32'd0);
    check("rst_estado",  {28'd0, db_estado}, 32'd0);
    reset = 1'b1;
    tick(2);

    // Conversion, saturation, short pulse, exact hundred.
    measure(125,   12'h012);
    measure(10005, 12'h999);
    measure(7,     12'h000);
    measure(1000,  12'h100);
    check("medida_hold", {20'd0, medida}, 32'h100);

    // Asynchronous reset in the middle of the trigger pulse.
    start_medida();
    tick(2);
    check("trigger_before_rst", {31'd0, trigger}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("midrst_trigger", {31'd0, trigger}, 32'd0);
    check("midrst_medida",  {20'd0, medida},  32'd0);
    check("midrst_estado",  {28'd0, db_estado}, 32'd0);
    tick(2);
    reset = 1'b1;
    last_med = 12'h000;
    tick(2);

    // Echo already high when waiting starts: must fall and rise again.
    start_medida();
    tick(2);
    echo = 1'b1;
    wait_trigger_done();
    tick(20);
    check("echo_high_still_wait", {28'd0, db_estado}, 32'd3);
    echo = 1'b0;
    tick(5);
    check("echo_low_still_wait", {28'd0, db_estado}, 32'd3);
    pulse_echo(30, 12'h003);
    tick(8);

    // medir held high: back-to-back measurements with trigger re-issued.
    medir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_trigger_done();
      tick(3);
      if (i == 2) medir = 1'b0;
      pulse_echo(b2b_n[i], b2b_e[i]);
    end
    tick(10);
    check("idle_after_b2b", {28'd0, db_estado}, 32'd0);

`ifdef HCSR04_TIMEOUT_EN
    measure(1000, 12'h100);
    start_medida();
    wait_trigger_done();
    q_med.push_back(last_med);
    q_cyc.push_back(cyc + TO);
    q_to.push_back(1'b1);
    tick(TO + 10);
`endif

    check("scoreboard_drained", q_med.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
